// File: rtl/ahb_resp_mux.sv
// AHB-Lite data-phase response mux: registers the decoder's one-hot select during the
// address phase and steers the chosen slave (or the built-in default slave) back to the master.
module ahb_resp_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [SEL_WIDTH-1:0]          HSEL,
    input  logic [1:0]                    HTRANS,
    input  logic [SEL_WIDTH*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [SEL_WIDTH-1:0]          HREADYOUT_S,
    input  logic [SEL_WIDTH-1:0]          HRESP_S,
    output logic [DATA_WIDTH-1:0]         HRDATA,
    output logic                          HREADY,
    output logic                          HRESP
);

    typedef enum logic [1:0] {
        DS_OKAY = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    logic [SEL_WIDTH-1:0] dp_sel_q, dp_sel_d;
    ds_state_e            ds_state_q, ds_state_d;
    logic                 unmapped_req;

    // HTRANS[0] only distinguishes IDLE/BUSY or NONSEQ/SEQ; activity is decided by bit 1.
    logic unused_htrans;
    assign unused_htrans = HTRANS[0];

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values, regardless of process ordering.
        if (!HRESETn) begin
            dp_sel_q   <= '0;
            ds_state_q <= DS_OKAY;
        end else begin
            dp_sel_q   <= dp_sel_d;
            ds_state_q <= ds_state_d;
        end
    end

    // Address-phase capture only while the bus is ready; a stalled data phase keeps its slave.
    assign dp_sel_d     = HREADY ? HSEL : dp_sel_q;
    assign unmapped_req = HREADY && (HSEL == '0) && HTRANS[1];

    // Default-slave next state
    always_comb begin
        // NOTE: default assignment first, so no path through this block infers a latch.
        ds_state_d = ds_state_q;
        unique case (ds_state_q)
            DS_OKAY: if (unmapped_req) ds_state_d = DS_ERR1;
            DS_ERR1: ds_state_d = DS_ERR2;
            DS_ERR2: ds_state_d = unmapped_req ? DS_ERR1 : DS_OKAY;
            default: ds_state_d = DS_OKAY;
        endcase
        if (HREADY && (HSEL != '0)) begin
            ds_state_d = DS_OKAY;
        end
    end

    // Output mux: default slave unless a select bit is set; scanning downward lets the
    // lowest set index win when the select is (illegally) not one-hot.
    always_comb begin
        HRDATA = '0;
        unique case (ds_state_q)
            DS_ERR1: begin HREADY = 1'b0; HRESP = 1'b1; end
            DS_ERR2: begin HREADY = 1'b1; HRESP = 1'b1; end
            default: begin HREADY = 1'b1; HRESP = 1'b0; end
        endcase
        for (int i = SEL_WIDTH - 1; i >= 0; i--) begin
            if (dp_sel_q[i]) begin
                HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
    end

endmodule
